// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// Module      : rv_pkg
// Description : RV64M funct3 encodings, default widths and muldiv state type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

    localparam int RV_XLEN       = 64;
    localparam int RV_REG_ADDR_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand a is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic signed_on_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signed_on_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_negate.sv
//------------------------------------------------------------------------------
// Module      : muldiv_negate
// Description : Conditional two's-complement negator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_negate #(
    parameter int W = 64
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// Module      : muldiv_unit
// Description : Iterative RV64M multiply/divide unit, one bit per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN       = RV_XLEN,
    parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  kill,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]       result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    state_t              state, next_state;
    logic [CNT_W-1:0]    counter;
    logic [2:0]          op_r;
    logic                sign_a, sign_b;
    logic [XLEN-1:0]     operand;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     rem;

    logic                accept;
    logic                in_sign_a, in_sign_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_result;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   acc_mul_next, acc_div_next;
    logic [XLEN:0]       div_shift;
    logic                div_ge;
    logic [XLEN-1:0]     rem_next;
    logic [2*XLEN-1:0]   prod_signed;
    logic                div_neg;
    logic [XLEN-1:0]     div_sel, div_signed;
    logic [XLEN-1:0]     final_result;

    assign accept    = (state == IDLE) && start && !kill;
    assign in_sign_a = signed_on_a(funct3) && op_a[XLEN-1];
    assign in_sign_b = signed_on_b(funct3) && op_b[XLEN-1];

    muldiv_negate #(.W(XLEN)) u_neg_a (.din(op_a), .neg(in_sign_a), .dout(mag_a));
    muldiv_negate #(.W(XLEN)) u_neg_b (.din(op_b), .neg(in_sign_b), .dout(mag_b));

    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = funct3[1] ? op_a : '1;
        else if (div_ovf)
            special_result = funct3[1] ? '0 : op_a;
    end

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};
    assign acc_mul_next = {mul_sum, acc[XLEN-1:1]};

    // Divide: dividend shifts out of acc's low half while quotient bits shift in.
    assign div_shift    = {rem, acc[XLEN-1]};
    assign div_ge       = div_shift >= {1'b0, operand};
    assign rem_next     = div_ge ? (div_shift[XLEN-1:0] - operand) : div_shift[XLEN-1:0];
    assign acc_div_next = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};

    muldiv_negate #(.W(2*XLEN)) u_neg_prod (
        .din  (acc_mul_next),
        .neg  ((op_r == F3_MULHSU) ? sign_a : (sign_a ^ sign_b)),
        .dout (prod_signed)
    );

    assign div_sel = op_r[1] ? rem_next : acc_div_next[XLEN-1:0];
    assign div_neg = op_r[1] ? sign_a : (sign_a ^ sign_b);

    muldiv_negate #(.W(XLEN)) u_neg_div (.din(div_sel), .neg(div_neg), .dout(div_signed));

    always_comb begin
        final_result = div_signed;
        if (!op_r[2])
            final_result = (op_r == F3_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = special ? DONE : CALC;
            CALC: begin
                if (kill)
                    next_state = IDLE;
                else if (counter == CNT_W'(1))
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE) && !kill;
    assign reg_write = done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            op_r    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            operand <= '0;
            acc     <= '0;
            rem     <= '0;
            rd_out  <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r    <= funct3;
                        rd_out  <= rd_in;
                        sign_a  <= in_sign_a;
                        sign_b  <= in_sign_b;
                        counter <= CNT_W'(XLEN);
                        rem     <= '0;
                        if (funct3[2]) begin
                            operand <= mag_b;
                            acc     <= {{XLEN{1'b0}}, mag_a};
                        end else begin
                            operand <= mag_a;
                            acc     <= {{XLEN{1'b0}}, mag_b};
                        end
                        if (special)
                            result <= special_result;
                    end
                end
                CALC: begin
                    if (!kill) begin
                        counter <= counter - CNT_W'(1);
                        if (op_r[2]) begin
                            acc <= acc_div_next;
                            rem <= rem_next;
                        end else begin
                            acc <= acc_mul_next;
                        end
                        if (counter == CNT_W'(1))
                            result <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
